uart_rx_ovs: RTL and testbench

Oversampling, parametrised UART receiver for the peripheral subsystem. It is the next-generation receive path. It samples the line at OVERSAMPLE× the baud rate, which its own divisor sets. It majority-votes each bit at mid-bit and supports 5–9 data bits, optional even/odd parity and 1 or 2 stop bits. Each received word is delivered with its error flags through a valid/ready handshake to the bus-side register block.

---
 rtl/uart_rx_ovs.sv | 256 +++++++++++++++++++++++++
 tb/tb_uart_rx_ovs.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ovs.sv
// Oversampling UART receiver: 3-sample majority vote per bit, 5..9 data bits, optional parity,
// 1/2 stop bits. Define UART_RX_FIFO_EN to replace the holding register with an output FIFO.
module uart_rx_ovs #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             rx_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [3:0]       data_size_i,
  input  logic             parity_en_i,
  input  logic             parity_odd_i,
  input  logic             stop_two_i,
  output logic [8:0]       data_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             parity_err_o,
  output logic             frame_err_o,
  output logic             overrun_o,
  output logic             busy_o
);

  localparam int unsigned SampW = $clog2(OVERSAMPLE);
  localparam logic [SampW-1:0] SampLast = SampW'(OVERSAMPLE - 1);
  localparam logic [SampW-1:0] VoteA    = SampW'(OVERSAMPLE / 2 - 1);
  localparam logic [SampW-1:0] VoteB    = SampW'(OVERSAMPLE / 2);
  localparam logic [SampW-1:0] VoteC    = SampW'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [SampW-1:0] samp_q, samp_d;
  logic             v0_q, v0_d, v1_q, v1_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d, size_q, size_d;
  logic             par_en_q, par_en_d, par_odd_q, par_odd_d, stop_two_q, stop_two_d;
  logic [8:0]       shreg_q, shreg_d;
  logic             perr_q, perr_d, ferr_q, ferr_d;
  logic             ovr_q, ovr_d;
  logic             rx_s, tick, at_vote, bit_end, maj, done, done_ferr;

  assign rx_s    = sync2_q;
  assign tick    = (state_q != StIdle) && (cnt_q == div_i);
  assign at_vote = tick && (samp_q == VoteC);
  assign bit_end = tick && (samp_q == SampLast);
  // Third vote is the live line at the VoteC tick.
  assign maj     = (v0_q & v1_q) | (v0_q & rx_s) | (v1_q & rx_s);
  assign done_ferr = ferr_q | ~maj;

  always_comb begin
    state_d    = state_q;
    cnt_d      = (state_q == StIdle || tick) ? '0 : cnt_q + DIV_W'(1);
    samp_d     = samp_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    bit_cnt_d  = bit_cnt_q;
    size_d     = size_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop_two_d = stop_two_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    done       = 1'b0;

    if (state_q == StIdle) begin
      samp_d = '0;
    end else if (tick) begin
      samp_d = bit_end ? '0 : samp_q + SampW'(1);
      if (samp_q == VoteA) v0_d = rx_s;
      if (samp_q == VoteB) v1_d = rx_s;
    end

    unique case (state_q)
      StIdle: begin
        if (en_i && !rx_s) begin
          state_d    = StStart;
          size_d     = (data_size_i < 4'd5) ? 4'd5 : (data_size_i > 4'd9) ? 4'd9 : data_size_i;
          par_en_d   = parity_en_i;
          par_odd_d  = parity_odd_i;
          stop_two_d = stop_two_i;
          shreg_d    = '0;
          perr_d     = 1'b0;
          ferr_d     = 1'b0;
          bit_cnt_d  = '0;
        end
      end
      StStart: begin
        if (at_vote && maj) state_d = StIdle;
        else if (bit_end)   state_d = StData;
      end
      StData: begin
        if (at_vote) shreg_d[bit_cnt_q] = maj;
        if (bit_end) begin
          if (bit_cnt_q == size_q - 4'd1) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? StParity : StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (at_vote) perr_d = ((^shreg_q) ^ maj) != par_odd_q;
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (at_vote) begin
          if (!maj) ferr_d = 1'b1;
          // Finish at the last stop bit's mid-vote so the next start edge is never missed.
          if (!stop_two_q || bit_cnt_q == 4'd1) begin
            done    = 1'b1;
            state_d = StIdle;
          end
        end else if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q != StIdle && !en_i) begin
      state_d = StIdle;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      cnt_q      <= '0;
      samp_q     <= '0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      bit_cnt_q  <= '0;
      size_q     <= 4'd8;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      stop_two_q <= 1'b0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync1_q    <= rx_i;
      sync2_q    <= sync1_q;
      cnt_q      <= cnt_d;
      samp_q     <= samp_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      bit_cnt_q  <= bit_cnt_d;
      size_q     <= size_d;
      par_en_q   <= par_en_d;
      par_odd_q  <= par_odd_d;
      stop_two_q <= stop_two_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

`ifdef UART_RX_FIFO_EN
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  logic [10:0]   mem_q [FIFO_DEPTH];
  logic [10:0]   mem_d [FIFO_DEPTH];
  logic [PtrW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic          empty, full, push, pop;
  logic [10:0]   head;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign pop   = !empty && ready_i;
  assign push  = done && (!full || pop);
  assign head  = mem_q[rptr_q[PtrW-1:0]];

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    ovr_d  = done && full && !pop;
    if (push) begin
      mem_d[wptr_q[PtrW-1:0]] = {done_ferr, perr_q, shreg_q};
      wptr_d = wptr_q + (PtrW + 1)'(1);
    end
    if (pop) rptr_d = rptr_q + (PtrW + 1)'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  assign valid_o      = !empty;
  assign data_o       = head[8:0];
  assign parity_err_o = head[9];
  assign frame_err_o  = head[10];
`else
  logic       out_valid_q, out_valid_d, out_perr_q, out_perr_d, out_ferr_q, out_ferr_d;
  logic [8:0] out_data_q, out_data_d;
  logic       load;

  assign load = done && (!out_valid_q || ready_i);

  always_comb begin
    out_valid_d = load | (out_valid_q & ~ready_i);
    out_data_d  = out_data_q;
    out_perr_d  = out_perr_q;
    out_ferr_d  = out_ferr_q;
    ovr_d       = done && out_valid_q && !ready_i;
    if (load) begin
      out_data_d = shreg_q;
      out_perr_d = perr_q;
      out_ferr_d = done_ferr;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_perr_q  <= 1'b0;
      out_ferr_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_perr_q  <= out_perr_d;
      out_ferr_q  <= out_ferr_d;
    end
  end

  assign valid_o      = out_valid_q;
  assign data_o       = out_data_q;
  assign parity_err_o = out_perr_q;
  assign frame_err_o  = out_ferr_q;
`endif

  assign overrun_o = ovr_q;
  assign busy_o    = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_ovs.sv
// Directed self-checking bench for uart_rx_ovs (OVERSAMPLE = 16, div_i = 0).
module tb_uart_rx_ovs;

  localparam int Bit = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        en_i = 1'b1;
  logic        rx_i = 1'b1;
  logic [15:0] div_i = 16'd0;
  logic [3:0]  data_size_i = 4'd8;
  logic        parity_en_i = 1'b0;
  logic        parity_odd_i = 1'b0;
  logic        stop_two_i = 1'b0;
  logic [8:0]  data_o;
  logic        valid_o;
  logic        ready_i = 1'b1;
  logic        parity_err_o, frame_err_o, overrun_o, busy_o;

  int checks = 0;
  int failures = 0;
  int cap_n = 0;
  int ovr_n = 0;
  int base_cap, base_ovr;
  logic [8:0] cap_data = '0;
  logic       cap_perr = 1'b0, cap_ferr = 1'b0;

  uart_rx_ovs #(.OVERSAMPLE(16), .DIV_W(16), .FIFO_DEPTH(4)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .rx_i        (rx_i),
    .div_i       (div_i),
    .data_size_i (data_size_i),
    .parity_en_i (parity_en_i),
    .parity_odd_i(parity_odd_i),
    .stop_two_i  (stop_two_i),
    .data_o      (data_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .parity_err_o(parity_err_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Records accepted words and overrun pulses, sampled away from the active edge.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (valid_o && ready_i) begin
        cap_n    <= cap_n + 1;
        cap_data <= data_o;
        cap_perr <= parity_err_o;
        cap_ferr <= frame_err_o;
      end
      if (overrun_o) ovr_n <= ovr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic b, input int n);
    rx_i = b;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // par < 0: no parity bit; bad_last drives the last stop bit low around its mid-bit only.
  task automatic send(input logic [8:0] d, input int nd, input int par, input int nstop,
                      input bit bad_last);
    hold(1'b0, Bit);
    for (int i = 0; i < nd; i++) hold(d[i], Bit);
    if (par >= 0) hold(par[0], Bit);
    for (int s = 0; s < nstop; s++) begin
      if (bad_last && s == nstop - 1) begin
        hold(1'b0, 11);
        hold(1'b1, Bit - 11);
      end else begin
        hold(1'b1, Bit);
      end
    end
    hold(1'b1, 8);
  endtask

  initial begin
    #1;
    check("rst_data", {7'd0, data_o}, 16'h0);
    check("rst_valid", {15'd0, valid_o}, 16'h0);
    check("rst_perr", {15'd0, parity_err_o}, 16'h0);
    check("rst_ferr", {15'd0, frame_err_o}, 16'h0);
    check("rst_ovr", {15'd0, overrun_o}, 16'h0);
    check("rst_busy", {15'd0, busy_o}, 16'h0);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    hold(1'b1, 5);

    // 8N1 0xA5
    base_cap = cap_n;
    send(9'h0A5, 8, -1, 1, 1'b0);
    check("a5_count", 16'(cap_n - base_cap), 16'd1);
    check("a5_data", {7'd0, cap_data}, 16'h0A5);
    check("a5_perr", {15'd0, cap_perr}, 16'h0);
    check("a5_ferr", {15'd0, cap_ferr}, 16'h0);
    check("a5_valid_drop", {15'd0, valid_o}, 16'h0);

    // 7E1 0x41: correct even parity bit is 0
    data_size_i = 4'd7; parity_en_i = 1'b1; parity_odd_i = 1'b0;
    send(9'h041, 7, 1, 1, 1'b0);
    check("7e1_bad_data", {7'd0, cap_data}, 16'h041);
    check("7e1_bad_perr", {15'd0, cap_perr}, 16'h1);
    send(9'h041, 7, 0, 1, 1'b0);
    check("7e1_ok_data", {7'd0, cap_data}, 16'h041);
    check("7e1_ok_perr", {15'd0, cap_perr}, 16'h0);

    // 9O2 0x1FF: nine ones so odd parity bit is 0; second stop bit low
    data_size_i = 4'd9; parity_odd_i = 1'b1; stop_two_i = 1'b1;
    base_cap = cap_n;
    send(9'h1FF, 9, 0, 2, 1'b1);
    check("9o2_count", 16'(cap_n - base_cap), 16'd1);
    check("9o2_data", {7'd0, cap_data}, 16'h1FF);
    check("9o2_ferr", {15'd0, cap_ferr}, 16'h1);
    check("9o2_perr", {15'd0, cap_perr}, 16'h0);

    // Back to 8N1; false start
    data_size_i = 4'd8; parity_en_i = 1'b0; parity_odd_i = 1'b0; stop_two_i = 1'b0;
    hold(1'b1, 8);
    base_cap = cap_n;
    hold(1'b0, 4);
    check("fs_busy_hi", {15'd0, busy_o}, 16'h1);
    hold(1'b1, Bit);
    check("fs_busy_lo", {15'd0, busy_o}, 16'h0);
    check("fs_no_word", 16'(cap_n - base_cap), 16'd0);

    // en_i dropped mid-frame aborts without output
    hold(1'b0, Bit);
    hold(1'b1, Bit);
    en_i = 1'b0;
    hold(1'b1, 2);
    check("en_abort_busy", {15'd0, busy_o}, 16'h0);
    hold(1'b1, 3 * Bit);
    en_i = 1'b1;
    hold(1'b1, 4);
    check("en_abort_word", 16'(cap_n - base_cap), 16'd0);

    // Backpressure / overrun
    ready_i = 1'b0;
    base_ovr = ovr_n;
`ifdef UART_RX_FIFO_EN
    for (int k = 1; k <= 6; k++) send(9'(k), 8, -1, 1, 1'b0);
    check("ovr_pulses", 16'(ovr_n - base_ovr), 16'd2);
    check("ovr_valid", {15'd0, valid_o}, 16'h1);
    check("ovr_head", {7'd0, data_o}, 16'h001);
    base_cap = cap_n;
    ready_i = 1'b1;
    hold(1'b1, 10);
    check("ovr_drained", 16'(cap_n - base_cap), 16'd4);
    check("ovr_last", {7'd0, cap_data}, 16'h004);
`else
    send(9'h011, 8, -1, 1, 1'b0);
    send(9'h022, 8, -1, 1, 1'b0);
    check("ovr_pulses", 16'(ovr_n - base_ovr), 16'd1);
    check("ovr_valid", {15'd0, valid_o}, 16'h1);
    check("ovr_held", {7'd0, data_o}, 16'h011);
    base_cap = cap_n;
    ready_i = 1'b1;
    hold(1'b1, 3);
    check("ovr_accept", 16'(cap_n - base_cap), 16'd1);
    check("ovr_accept_data", {7'd0, cap_data}, 16'h011);
`endif
    check("ovr_valid_drop", {15'd0, valid_o}, 16'h0);

    // Held word, then reset mid-DATA
    ready_i = 1'b0;
    send(9'h033, 8, -1, 1, 1'b0);
    check("held_33", {7'd0, data_o}, 16'h033);
    hold(1'b0, Bit);
    hold(1'b0, Bit);
    hold(1'b1, Bit / 2);
    check("mid_busy", {15'd0, busy_o}, 16'h1);
    rst_ni = 1'b0;
    #1;
    check("midrst_data", {7'd0, data_o}, 16'h0);
    check("midrst_valid", {15'd0, valid_o}, 16'h0);
    check("midrst_busy", {15'd0, busy_o}, 16'h0);
    hold(1'b1, 3);
    rst_ni = 1'b1;
    ready_i = 1'b1;
    hold(1'b1, 10);
    base_cap = cap_n;
    send(9'h05A, 8, -1, 1, 1'b0);
    check("post_rst_count", 16'(cap_n - base_cap), 16'd1);
    check("post_rst_data", {7'd0, cap_data}, 16'h05A);
    check("post_rst_errs", {14'd0, cap_ferr, cap_perr}, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
